// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// Width codes, reset vector, mtvec modes, next-PC selector and FSM states.
package pc_gen_pkg;

    localparam int unsigned XLEN_32B = 1;
    localparam int unsigned XLEN_64B = 2;

    localparam logic [63:0] RESET_LO = 64'h0000_0000_0000_0000;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    typedef enum logic [2:0] {
        PCSEL_TRAP,
        PCSEL_REDIR,
        PCSEL_HOLD,
        PCSEL_RAS,
        PCSEL_SEQ
    } pcsel_e;

    typedef enum logic {
        PCG_BOOT,
        PCG_RUN
    } pcg_state_e;

    // Datapath width from an XLEN width code.
    function automatic int unsigned xlen_width(input int unsigned code);
        return 32'd1 << (code + 32'd4);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/replace, oldest entry overwritten when full.
// The top entry and the empty flag are combinational reads of the stack registers.
module pc_ras #(
    parameter int unsigned W         = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_c,
    output logic         empty_c
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  mem_q [RAS_DEPTH];

    logic [PW-1:0] top_idx_c;
    logic [PW-1:0] wr_idx_c;
    logic          do_pop_c;

    assign top_idx_c = ptr_q - PW'(1);
    assign do_pop_c  = pop && (cnt_q != '0);
    assign wr_idx_c  = do_pop_c ? top_idx_c : ptr_q;
    assign top_c     = mem_q[top_idx_c];
    assign empty_c   = (cnt_q == '0);

    // Pointer and occupancy; pop+push together replaces the top in place.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push && !do_pop_c) begin
            ptr_q <= ptr_q + PW'(1);
            if (cnt_q != CW'(RAS_DEPTH)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (do_pop_c && !push) begin
            ptr_q <= top_idx_c;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_idx_c] <= push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: trap/redirect/hold/RAS/sequential priority mux,
// boot FSM, return-address stack and single-cycle status pulses, all registered.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_64B,
    parameter logic [63:0] RESET_VEC = RESET_LO,
    parameter bit          C_EXT     = 1'b1,
    parameter int unsigned RAS_DEPTH = 4,
    localparam int unsigned W        = xlen_width(XLEN)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic         i_stall,
    input  logic         i_fetch_rdy,
    input  logic         i_inst_len16,
    input  logic         i_redir,
    input  logic [W-1:0] i_redir_pc,
    input  logic         i_trap,
    input  logic         i_trap_intr,
    input  logic [5:0]   i_trap_cause,
    input  logic [W-1:0] i_mtvec,
    input  logic         i_call,
    input  logic         i_ret,
    output logic [W-1:0] o_pc,
    output logic         o_pc_valid,
    output logic         o_flush,
    output logic         o_misalign,
    output logic         o_ras_pred
);

    pcg_state_e   state_q, state_nxt;
    logic [W-1:0] pc_q, pc_nxt;
    logic         valid_q, valid_nxt;
    logic         flush_q, flush_nxt;
    logic         misalign_q, misalign_nxt;
    logic         ras_pred_q, ras_pred_nxt;

    pcsel_e       sel_c;
    logic [W-1:0] seq_pc_c;
    logic [W-1:0] redir_pc_c;
    logic [W-1:0] mtvec_base_c;
    logic [W-1:0] trap_pc_c;
    logic [W-1:0] ras_top_c;
    logic         ras_empty_c;
    logic         ras_push_c;
    logic         ras_pop_c;

    assign seq_pc_c     = pc_q + ((i_inst_len16 && C_EXT) ? W'(2) : W'(4));
    assign redir_pc_c   = i_redir_pc & ~W'(1);
    assign mtvec_base_c = i_mtvec & ~W'(3);
    // Vectored entry applies to interrupts only; exceptions always go to the base.
    assign trap_pc_c    = (i_trap_intr && (i_mtvec[1:0] == MTVEC_VECTORED))
                        ? mtvec_base_c + W'({i_trap_cause, 2'b00})
                        : mtvec_base_c;

    always_comb begin
        sel_c = PCSEL_SEQ;
        if (i_trap) begin
            sel_c = PCSEL_TRAP;
        end else if (i_redir) begin
            sel_c = PCSEL_REDIR;
        end else if (i_stall || !i_fetch_rdy) begin
            sel_c = PCSEL_HOLD;
        end else if (i_ret && !ras_empty_c) begin
            sel_c = PCSEL_RAS;
        end
    end

    // Next-state and next-output logic; pulses default low so they last one cycle.
    always_comb begin
        state_nxt    = state_q;
        pc_nxt       = pc_q;
        valid_nxt    = valid_q;
        flush_nxt    = 1'b0;
        misalign_nxt = 1'b0;
        ras_pred_nxt = 1'b0;
        ras_push_c   = 1'b0;
        ras_pop_c    = 1'b0;
        if (i_clk_en) begin
            case (state_q)
                PCG_BOOT: begin
                    state_nxt = PCG_RUN;
                    valid_nxt = 1'b1;
                end
                PCG_RUN: begin
                    case (sel_c)
                        PCSEL_TRAP: begin
                            pc_nxt    = trap_pc_c;
                            flush_nxt = 1'b1;
                        end
                        PCSEL_REDIR: begin
                            if (!C_EXT && redir_pc_c[1]) begin
                                misalign_nxt = 1'b1;
                            end else begin
                                pc_nxt    = redir_pc_c;
                                flush_nxt = 1'b1;
                            end
                        end
                        PCSEL_HOLD: begin
                        end
                        PCSEL_RAS: begin
                            pc_nxt       = ras_top_c;
                            ras_pop_c    = 1'b1;
                            ras_pred_nxt = 1'b1;
                            ras_push_c   = i_call;
                        end
                        default: begin
                            pc_nxt     = seq_pc_c;
                            ras_push_c = i_call;
                        end
                    endcase
                end
                default: begin
                    state_nxt = PCG_BOOT;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= PCG_BOOT;
            pc_q       <= W'(RESET_VEC);
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            ras_pred_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            pc_q       <= pc_nxt;
            valid_q    <= valid_nxt;
            flush_q    <= flush_nxt;
            misalign_q <= misalign_nxt;
            ras_pred_q <= ras_pred_nxt;
        end
    end

    pc_ras #(
        .W         (W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (ras_push_c),
        .pop       (ras_pop_c),
        .push_data (seq_pc_c),
        .top_c     (ras_top_c),
        .empty_c   (ras_empty_c)
    );

    assign o_pc       = pc_q;
    assign o_pc_valid = valid_q;
    assign o_flush    = flush_q;
    assign o_misalign = misalign_q;
    assign o_ras_pred = ras_pred_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a compressed-enabled and a 4-byte-aligned instance share
// stimulus; expectations are queued at drive time and compared against monitored outputs.
module tb_pc_gen;
    import pc_gen_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        misalign;
        logic        ras_pred;
    } obs_t;

    logic        clk;
    logic        rst, clk_en, stall, fetch_rdy, len16, redir, trap, intr, call, ret;
    logic [31:0] redir_pc, mtvec;
    logic [5:0]  cause;

    logic [31:0] c_pc, n_pc;
    logic        c_valid, c_flush, c_misalign, c_ras_pred;
    logic        n_valid, n_flush, n_misalign, n_ras_pred;

    obs_t obs_c, obs_n;
    obs_t exp_q[$], exp_n_q[$], got_q[$], got_n_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    assign obs_c = {c_pc, c_valid, c_flush, c_misalign, c_ras_pred};
    assign obs_n = {n_pc, n_valid, n_flush, n_misalign, n_ras_pred};

    pc_gen #(.XLEN(XLEN_32B), .RESET_VEC(64'h100), .C_EXT(1'b1), .RAS_DEPTH(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_stall(stall), .i_fetch_rdy(fetch_rdy),
        .i_inst_len16(len16), .i_redir(redir), .i_redir_pc(redir_pc), .i_trap(trap),
        .i_trap_intr(intr), .i_trap_cause(cause), .i_mtvec(mtvec), .i_call(call), .i_ret(ret),
        .o_pc(c_pc), .o_pc_valid(c_valid), .o_flush(c_flush), .o_misalign(c_misalign),
        .o_ras_pred(c_ras_pred)
    );

    pc_gen #(.XLEN(XLEN_32B), .RESET_VEC(64'h100), .C_EXT(1'b0), .RAS_DEPTH(4)) u_dut_nc (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_stall(stall), .i_fetch_rdy(fetch_rdy),
        .i_inst_len16(len16), .i_redir(redir), .i_redir_pc(redir_pc), .i_trap(trap),
        .i_trap_intr(intr), .i_trap_cause(cause), .i_mtvec(mtvec), .i_call(call), .i_ret(ret),
        .o_pc(n_pc), .o_pc_valid(n_valid), .o_flush(n_flush), .o_misalign(n_misalign),
        .o_ras_pred(n_ras_pred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t ob(input logic [31:0] pc, input logic v, f, m, r);
        return {pc, v, f, m, r};
    endfunction

    // One clock; outputs are captured 1 ns after the edge into the monitor queues.
    task automatic tick();
        @(posedge clk);
        #1;
        got_q.push_back(obs_c);
        got_n_q.push_back(obs_n);
    endtask

    task automatic idle();
        rst = 1'b0; clk_en = 1'b1; stall = 1'b0; fetch_rdy = 1'b1; len16 = 1'b0;
        redir = 1'b0; redir_pc = '0; trap = 1'b0; intr = 1'b0; cause = '0;
        mtvec = '0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic exp2(input obs_t ec, input obs_t en);
        exp_q.push_back(ec);
        exp_n_q.push_back(en);
    endtask

    task automatic boot();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        exp_q.delete(); exp_n_q.delete(); got_q.delete(); got_n_q.delete();
    endtask

    task automatic test_reset();
        obs_t e, g, en, gn;
        exp_q.delete(); exp_n_q.delete(); got_q.delete(); got_n_q.delete();
        idle(); rst = 1'b1;
        exp2(ob(32'h100, 0, 0, 0, 0), ob(32'h100, 0, 0, 0, 0)); tick();
        clk_en = 1'b0;
        exp2(ob(32'h100, 0, 0, 0, 0), ob(32'h100, 0, 0, 0, 0)); tick();
        idle();
        exp2(ob(32'h100, 1, 0, 0, 0), ob(32'h100, 1, 0, 0, 0)); tick();
        exp2(ob(32'h104, 1, 0, 0, 0), ob(32'h104, 1, 0, 0, 0)); tick();
        exp2(ob(32'h108, 1, 0, 0, 0), ob(32'h108, 1, 0, 0, 0)); tick();
        clk_en = 1'b0; call = 1'b1;
        exp2(ob(32'h108, 1, 0, 0, 0), ob(32'h108, 1, 0, 0, 0)); tick();
        idle();
        exp2(ob(32'h10C, 1, 0, 0, 0), ob(32'h10C, 1, 0, 0, 0)); tick();
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            en = exp_n_q.pop_front(); gn = got_n_q.pop_front();
            n_vec += 2;
            if (g !== e) begin n_err++; $display("FAIL reset[%0d] c: got %h expected %h", i, g, e); end
            if (gn !== en) begin n_err++; $display("FAIL reset[%0d] nc: got %h expected %h", i, gn, en); end
        end
    endtask

    task automatic test_len16();
        obs_t e, g, en, gn;
        boot();
        idle(); len16 = 1'b1;
        exp2(ob(32'h102, 1, 0, 0, 0), ob(32'h104, 1, 0, 0, 0)); tick();
        exp2(ob(32'h104, 1, 0, 0, 0), ob(32'h108, 1, 0, 0, 0)); tick();
        exp2(ob(32'h106, 1, 0, 0, 0), ob(32'h10C, 1, 0, 0, 0)); tick();
        len16 = 1'b0;
        exp2(ob(32'h10A, 1, 0, 0, 0), ob(32'h110, 1, 0, 0, 0)); tick();
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            en = exp_n_q.pop_front(); gn = got_n_q.pop_front();
            n_vec += 2;
            if (g !== e) begin n_err++; $display("FAIL len16[%0d] c: got %h expected %h", i, g, e); end
            if (gn !== en) begin n_err++; $display("FAIL len16[%0d] nc: got %h expected %h", i, gn, en); end
        end
    endtask

    task automatic test_trap();
        obs_t e, g, en, gn;
        boot();
        idle(); trap = 1'b1; redir = 1'b1; redir_pc = 32'h2000;
        mtvec = 32'h8000_0001; intr = 1'b1; cause = 6'd3;
        exp2(ob(32'h8000_000C, 1, 1, 0, 0), ob(32'h8000_000C, 1, 1, 0, 0)); tick();
        idle();
        exp2(ob(32'h8000_0010, 1, 0, 0, 0), ob(32'h8000_0010, 1, 0, 0, 0)); tick();
        trap = 1'b1; mtvec = 32'h8000_0001; intr = 1'b0; cause = 6'd3;
        exp2(ob(32'h8000_0000, 1, 1, 0, 0), ob(32'h8000_0000, 1, 1, 0, 0)); tick();
        clk_en = 1'b0; intr = 1'b1;
        exp2(ob(32'h8000_0000, 1, 0, 0, 0), ob(32'h8000_0000, 1, 0, 0, 0)); tick();
        idle(); trap = 1'b1; mtvec = 32'h4000_0000; intr = 1'b1; cause = 6'd5;
        exp2(ob(32'h4000_0000, 1, 1, 0, 0), ob(32'h4000_0000, 1, 1, 0, 0)); tick();
        idle(); redir = 1'b1; redir_pc = 32'hFFFF_FFFD;
        exp2(ob(32'hFFFF_FFFC, 1, 1, 0, 0), ob(32'hFFFF_FFFC, 1, 1, 0, 0)); tick();
        idle();
        exp2(ob(32'h0000_0000, 1, 0, 0, 0), ob(32'h0000_0000, 1, 0, 0, 0)); tick();
        redir = 1'b1; redir_pc = 32'h3003;
        exp2(ob(32'h3002, 1, 1, 0, 0), ob(32'h0000_0000, 1, 0, 1, 0)); tick();
        idle();
        exp2(ob(32'h3006, 1, 0, 0, 0), ob(32'h0000_0004, 1, 0, 0, 0)); tick();
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            en = exp_n_q.pop_front(); gn = got_n_q.pop_front();
            n_vec += 2;
            if (g !== e) begin n_err++; $display("FAIL trap[%0d] c: got %h expected %h", i, g, e); end
            if (gn !== en) begin n_err++; $display("FAIL trap[%0d] nc: got %h expected %h", i, gn, en); end
        end
    endtask

    task automatic test_misalign();
        obs_t e, g, en, gn;
        boot();
        idle(); redir = 1'b1; redir_pc = 32'h1002;
        exp2(ob(32'h1002, 1, 1, 0, 0), ob(32'h100, 1, 0, 1, 0)); tick();
        redir_pc = 32'h1001;
        exp2(ob(32'h1000, 1, 1, 0, 0), ob(32'h1000, 1, 1, 0, 0)); tick();
        idle();
        exp2(ob(32'h1004, 1, 0, 0, 0), ob(32'h1004, 1, 0, 0, 0)); tick();
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            en = exp_n_q.pop_front(); gn = got_n_q.pop_front();
            n_vec += 2;
            if (g !== e) begin n_err++; $display("FAIL misalign[%0d] c: got %h expected %h", i, g, e); end
            if (gn !== en) begin n_err++; $display("FAIL misalign[%0d] nc: got %h expected %h", i, gn, en); end
        end
    endtask

    task automatic test_ras();
        obs_t e, g, en, gn;
        logic [31:0] pc_e;
        boot();
        idle(); call = 1'b1;
        pc_e = 32'h100;
        for (int k = 0; k < 5; k++) begin
            pc_e = pc_e + 32'd4;
            exp2(ob(pc_e, 1, 0, 0, 0), ob(pc_e, 1, 0, 0, 0)); tick();
        end
        idle(); redir = 1'b1; redir_pc = 32'h8000;
        exp2(ob(32'h8000, 1, 1, 0, 0), ob(32'h8000, 1, 1, 0, 0)); tick();
        idle(); ret = 1'b1;
        pc_e = 32'h114;
        for (int k = 0; k < 4; k++) begin
            exp2(ob(pc_e, 1, 0, 0, 1), ob(pc_e, 1, 0, 0, 1)); tick();
            pc_e = pc_e - 32'd4;
        end
        exp2(ob(32'h10C, 1, 0, 0, 0), ob(32'h10C, 1, 0, 0, 0)); tick();
        idle();
        exp2(ob(32'h110, 1, 0, 0, 0), ob(32'h110, 1, 0, 0, 0)); tick();
        call = 1'b1;
        exp2(ob(32'h114, 1, 0, 0, 0), ob(32'h114, 1, 0, 0, 0)); tick();
        idle(); redir = 1'b1; redir_pc = 32'h9000;
        exp2(ob(32'h9000, 1, 1, 0, 0), ob(32'h9000, 1, 1, 0, 0)); tick();
        idle(); call = 1'b1; ret = 1'b1;
        exp2(ob(32'h114, 1, 0, 0, 1), ob(32'h114, 1, 0, 0, 1)); tick();
        idle(); redir = 1'b1; redir_pc = 32'hA000;
        exp2(ob(32'hA000, 1, 1, 0, 0), ob(32'hA000, 1, 1, 0, 0)); tick();
        idle(); ret = 1'b1;
        exp2(ob(32'h9004, 1, 0, 0, 1), ob(32'h9004, 1, 0, 0, 1)); tick();
        exp2(ob(32'h9008, 1, 0, 0, 0), ob(32'h9008, 1, 0, 0, 0)); tick();
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            en = exp_n_q.pop_front(); gn = got_n_q.pop_front();
            n_vec += 2;
            if (g !== e) begin n_err++; $display("FAIL ras[%0d] c: got %h expected %h", i, g, e); end
            if (gn !== en) begin n_err++; $display("FAIL ras[%0d] nc: got %h expected %h", i, gn, en); end
        end
    endtask

    task automatic test_stall();
        obs_t e, g, en, gn;
        boot();
        idle(); call = 1'b1;
        exp2(ob(32'h104, 1, 0, 0, 0), ob(32'h104, 1, 0, 0, 0)); tick();
        idle(); redir = 1'b1; redir_pc = 32'h5000;
        exp2(ob(32'h5000, 1, 1, 0, 0), ob(32'h5000, 1, 1, 0, 0)); tick();
        idle(); stall = 1'b1; ret = 1'b1; call = 1'b1;
        repeat (3) begin
            exp2(ob(32'h5000, 1, 0, 0, 0), ob(32'h5000, 1, 0, 0, 0)); tick();
        end
        idle(); fetch_rdy = 1'b0; ret = 1'b1;
        exp2(ob(32'h5000, 1, 0, 0, 0), ob(32'h5000, 1, 0, 0, 0)); tick();
        fetch_rdy = 1'b1;
        exp2(ob(32'h104, 1, 0, 0, 1), ob(32'h104, 1, 0, 0, 1)); tick();
        exp2(ob(32'h108, 1, 0, 0, 0), ob(32'h108, 1, 0, 0, 0)); tick();
        idle(); call = 1'b1;
        exp2(ob(32'h10C, 1, 0, 0, 0), ob(32'h10C, 1, 0, 0, 0)); tick();
        idle(); stall = 1'b1; rst = 1'b1;
        exp2(ob(32'h100, 0, 0, 0, 0), ob(32'h100, 0, 0, 0, 0)); tick();
        idle(); ret = 1'b1;
        exp2(ob(32'h100, 1, 0, 0, 0), ob(32'h100, 1, 0, 0, 0)); tick();
        exp2(ob(32'h104, 1, 0, 0, 0), ob(32'h104, 1, 0, 0, 0)); tick();
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            en = exp_n_q.pop_front(); gn = got_n_q.pop_front();
            n_vec += 2;
            if (g !== e) begin n_err++; $display("FAIL stall[%0d] c: got %h expected %h", i, g, e); end
            if (gn !== en) begin n_err++; $display("FAIL stall[%0d] nc: got %h expected %h", i, gn, en); end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_len16();
        test_trap();
        test_misalign();
        test_ras();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
